// File: rtl/d_latch_chk_pkg.sv
// Shared types and constants for the D-latch output checker.
package d_latch_chk_pkg;

   localparam int unsigned STATE_W               = 2;
   localparam int unsigned DEFAULT_SETTLE_CYCLES = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2
   } state_e;

endpackage

// File: rtl/d_latch_checker_settle_timer.sv
// Reloadable saturating down-counter; zero_o flags an expired settle window.
import d_latch_chk_pkg::*;

module settle_timer #(
   parameter int unsigned SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic load_i,
   input  logic dec_i,
   output logic zero_o
);

   localparam int unsigned TW = $clog2(SETTLE_CYCLES) + 1;

   logic [TW-1:0] cnt_q, cnt_d;
   logic          zero_q, zero_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = TW'(SETTLE_CYCLES - 1);
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - TW'(1);
      end
      zero_d = (cnt_d == '0);
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         cnt_q  <= '0;
         zero_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         zero_q <= zero_d;
      end
   end

   assign zero_o = zero_q;

endmodule

// File: rtl/d_latch_checker.sv
// Self-checking monitor for a D latch: reference model, settle FSM, error count.
// Define D_LATCH_CHK_COMPL_EN to also check q_inv_i against ~q_i.
import d_latch_chk_pkg::*;

module d_latch_checker #(
   parameter int unsigned SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
   parameter int unsigned ERR_CNT_W     = 8
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 en_i,
   input  logic                 e_i,
   input  logic                 d_i,
   input  logic                 q_i,
   input  logic                 q_inv_i,
   output logic                 model_q_o,
   output logic                 model_vld_o,
   output logic                 busy_o,
   output logic                 err_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o,
   output logic [STATE_W-1:0]   state_o
);

   state_e               state_q, state_d;
   logic [1:0]           prev_q, prev_d;
   logic                 model_q_q, model_q_d;
   logic                 model_vld_q, model_vld_d;
   logic                 busy_q, busy_d;
   logic                 err_q, err_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic chg_c, mismatch_c, tmr_load_c, tmr_dec_c, tmr_zero_c;

   settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle_timer (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .load_i (tmr_load_c),
      .dec_i  (tmr_dec_c),
      .zero_o (tmr_zero_c)
   );

`ifdef D_LATCH_CHK_COMPL_EN
   assign mismatch_c = (q_i != model_q_q) || (q_inv_i != ~q_i);
`else
   logic unused_q_inv;
   assign unused_q_inv = q_inv_i;
   assign mismatch_c   = (q_i != model_q_q);
`endif

   always_comb begin
      state_d     = state_q;
      tmr_load_c  = 1'b0;
      tmr_dec_c   = 1'b0;
      err_d       = 1'b0;
      chg_c       = ({e_i, d_i} != prev_q);
      prev_d      = {e_i, d_i};
      model_q_d   = e_i ? d_i : model_q_q;
      model_vld_d = model_vld_q | e_i;

      case (state_q)
         ST_IDLE: begin
            if (en_i) begin
               state_d    = ST_SETTLE;
               tmr_load_c = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (chg_c) begin
               tmr_load_c = 1'b1;
            end else if (tmr_zero_c && model_vld_q) begin
               state_d = ST_CHECK;
            end else begin
               tmr_dec_c = 1'b1;
            end
         end
         ST_CHECK: begin
            // An input change restarts settling and masks that cycle's compare
            if (chg_c) begin
               state_d    = ST_SETTLE;
               tmr_load_c = 1'b1;
            end else begin
               err_d = mismatch_c;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (!en_i) begin
         state_d    = ST_IDLE;
         tmr_load_c = 1'b0;
         tmr_dec_c  = 1'b0;
         err_d      = 1'b0;
      end

      busy_d    = (state_d == ST_SETTLE);
      err_cnt_d = err_cnt_q;
      if (err_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q     <= ST_IDLE;
         prev_q      <= 2'b00;
         model_q_q   <= 1'b0;
         model_vld_q <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         model_q_q   <= model_q_d;
         model_vld_q <= model_vld_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign model_q_o   = model_q_q;
   assign model_vld_o = model_vld_q;
   assign busy_o      = busy_q;
   assign err_o       = err_q;
   assign err_cnt_o   = err_cnt_q;
   assign state_o     = state_q;

endmodule
